// File: rtl/hermes_vc_buffer_if.sv
// Port bundle for hermes_vc_buffer: input flit link, credits, routing handshake and output link.
interface hermes_vc_buffer_if #(
  parameter int unsigned FLIT_SIZE = 32,
  parameter int unsigned NUM_VC    = 2
);
  localparam int unsigned VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic                 rx_i;
  logic [VC_W-1:0]      vc_i;
  logic [FLIT_SIZE-1:0] data_i;
  logic [NUM_VC-1:0]    credit_o;
  logic                 overflow_o;
  logic                 req_o;
  logic                 req_ack_i;
  logic                 data_av_o;
  logic                 data_ack_i;
  logic                 sending_o;
  logic [VC_W-1:0]      vc_o;
  logic [FLIT_SIZE-1:0] data_o;

  modport slave (
    input  rx_i, vc_i, data_i, req_ack_i, data_ack_i,
    output credit_o, overflow_o, req_o, data_av_o, sending_o, vc_o, data_o
  );

  modport master (
    output rx_i, vc_i, data_i, req_ack_i, data_ack_i,
    input  credit_o, overflow_o, req_o, data_av_o, sending_o, vc_o, data_o
  );
endinterface

// File: rtl/hermes_vc_buffer.sv
// Multi-VC Hermes input buffer: per-VC circular FIFOs feeding a round-robin
// packet scheduler that streams one whole packet at a time onto the output link.
module hermes_vc_buffer #(
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned FLIT_SIZE   = 32,
  parameter int unsigned NUM_VC      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  hermes_vc_buffer_if.slave    bus
);
  localparam int unsigned VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_HEADER, ST_SIZE, ST_PAYLOAD, ST_END
  } state_e;

  logic [FLIT_SIZE-1:0] mem_q [NUM_VC][BUFFER_SIZE];
  logic [PTR_W-1:0]     head_q [NUM_VC];
  logic [PTR_W-1:0]     head_d [NUM_VC];
  logic [PTR_W-1:0]     tail_q [NUM_VC];
  logic [PTR_W-1:0]     tail_d [NUM_VC];
  logic [NUM_VC-1:0]    full_q, full_d, empty_q, empty_d;
  logic [NUM_VC-1:0]    wr_en, rd_en;
  logic                 overflow_q, overflow_d;

  state_e               state_q, state_d;
  logic [VC_W-1:0]      sel_q, sel_d;
  logic [VC_W-1:0]      rr_q, rr_d;
  logic [FLIT_SIZE-1:0] cnt_q, cnt_d;

  logic                 sending, data_av, xfer, found;
  logic [VC_W-1:0]      cand;
  int                   idx;

  // Wrap by explicit compare so any BUFFER_SIZE works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign sending = (state_q == ST_HEADER) || (state_q == ST_SIZE) || (state_q == ST_PAYLOAD);
  assign data_av = sending && !empty_q[sel_q];
  assign xfer    = data_av && bus.data_ack_i;

  // FIFO pointer and flag next-state; a read frees the slot a same-cycle write needs.
  always_comb begin
    wr_en   = '0;
    rd_en   = '0;
    head_d  = head_q;
    tail_d  = tail_q;
    full_d  = full_q;
    empty_d = empty_q;
    for (int v = 0; v < int'(NUM_VC); v++) begin
      rd_en[v] = xfer && (sel_q == VC_W'(v));
      wr_en[v] = bus.rx_i && (bus.vc_i == VC_W'(v)) && (!full_q[v] || rd_en[v]);
      if (wr_en[v]) head_d[v] = ptr_inc(head_q[v]);
      if (rd_en[v]) tail_d[v] = ptr_inc(tail_q[v]);
      if (wr_en[v] && !rd_en[v]) begin
        empty_d[v] = 1'b0;
        full_d[v]  = (ptr_inc(head_q[v]) == tail_q[v]);
      end else if (rd_en[v] && !wr_en[v]) begin
        full_d[v]  = 1'b0;
        empty_d[v] = (ptr_inc(tail_q[v]) == head_q[v]);
      end
    end
    overflow_d = bus.rx_i && (wr_en == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int v = 0; v < int'(NUM_VC); v++) begin
        head_q[v] <= '0;
        tail_q[v] <= '0;
      end
      full_q     <= '0;
      empty_q    <= '1;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Flit storage carries no reset.
  always_ff @(posedge clk_i) begin
    for (int v = 0; v < int'(NUM_VC); v++) begin
      if (wr_en[v]) mem_q[v][head_q[v]] <= bus.data_i;
    end
  end

  // Packet scheduler next-state.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    found   = 1'b0;
    cand    = '0;
    idx     = 0;
    case (state_q)
      ST_IDLE: begin
        if (empty_q != '1) begin
          for (int i = 0; i < int'(NUM_VC); i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NUM_VC)) idx = idx - int'(NUM_VC);
            cand = VC_W'(idx);
            if (!found && !empty_q[cand]) begin
              found = 1'b1;
              sel_d = cand;
            end
          end
          state_d = ST_REQ;
        end
      end
      ST_REQ:    if (bus.req_ack_i) state_d = ST_HEADER;
      ST_HEADER: if (xfer) state_d = ST_SIZE;
      ST_SIZE: begin
        if (xfer) begin
          if (bus.data_o != '0) begin
            cnt_d   = bus.data_o;
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_END;
          end
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          cnt_d = cnt_q - FLIT_SIZE'(1);
          if (cnt_q == FLIT_SIZE'(1)) state_d = ST_END;
        end
      end
      ST_END: begin
        rr_d    = (sel_q == VC_W'(NUM_VC - 1)) ? '0 : sel_q + VC_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.credit_o   = ~full_q;
  assign bus.overflow_o = overflow_q;
  assign bus.req_o      = (state_q == ST_REQ);
  assign bus.sending_o  = sending;
  assign bus.data_av_o  = data_av;
  assign bus.vc_o       = sel_q;
  assign bus.data_o     = mem_q[sel_q][tail_q[sel_q]];
endmodule

// File: doc/hermes_vc_buffer.md
# hermes_vc_buffer

Multi-virtual-channel input buffer for a Hermes router port. Incoming flits are tagged with a virtual-channel (VC) index and stored in a per-VC circular FIFO, and each VC has its own credit line. A round-robin packet scheduler chooses one non-empty VC, requests routing for it and streams that whole packet (header, size, payload) onto the shared output link before serving another VC. This block generalises the single-channel Hermes buffer in depth (any size, not only powers of two), flit width and channel count.

## Interface
- BUFFER_SIZE, 8: flits per VC FIFO; any integer >= 2.
- FLIT_SIZE, 32: flit width in bits; minimum 20.
- NUM_VC, 2: number of virtual channels; >= 1. VC_W = max(1, $clog2(NUM_VC)).

- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- rx_i  in  1  input flit valid.
- vc_i  in  VC_W  VC of the input flit; values >= NUM_VC are ignored (flit dropped).
- data_i  in  FLIT_SIZE  input flit.
- credit_o  out  NUM_VC  bit v is high when FIFO v is not full.
- overflow_o  out  1  one-cycle pulse when an input flit is dropped.
- req_o  out  1  routing request for the packet at the head of the selected VC.
- req_ack_i  in  1  routing granted.
- data_av_o  out  1  a flit of the selected VC is presented on data_o.
- data_ack_i  in  1  downstream accepts data_o.
- sending_o  out  1  a packet transfer is in progress.
- vc_o  out  VC_W  selected VC.
- data_o  out  FLIT_SIZE  head flit of the selected VC's FIFO.

## Operation
- Per-VC FIFO: head and tail pointers wrap from BUFFER_SIZE-1 to 0 by explicit compare (no power-of-two masking), plus registered full and empty flags. Storage is not reset.
- Write on VC v when rx_i is high, vc_i is v and either (!full[v]) or (a read from v happens in the same cycle). Otherwise the flit is discarded and overflow_o pulses in the next cycle.
- Read: a transfer occurs when data_av_o && data_ack_i. It pops the selected VC. data_ack_i while data_av_o is low has no effect.
- Simultaneous write and read on the same VC: occupancy is unchanged and the full/empty flags hold. A write on VC a with a read on VC b (a != b) updates the two FIFOs independently.
- Scheduler FSM states: IDLE, REQ, HEADER, SIZE, PAYLOAD, END.
  - IDLE -> REQ when any FIFO is non-empty. sel becomes the first non-empty VC searching from rr_ptr upward with wrap. sel is latched into vc_o.
  - REQ -> HEADER on req_ack_i.
  - HEADER -> SIZE on transfer.
  - SIZE -> PAYLOAD on transfer with data_o != 0, and cnt is loaded with the full FLIT_SIZE value. SIZE -> END on transfer with data_o == 0.
  - PAYLOAD: every transfer decrements cnt. On a transfer with cnt == 1, go to END. A size flit of S gives exactly S payload flits.
  - END -> IDLE after one cycle. In END, rr_ptr becomes (sel+1) mod NUM_VC.
  - An illegal state returns to IDLE.
- req_o = (state == REQ).
- sending_o = state in {HEADER, SIZE, PAYLOAD}.
- data_av_o = sending_o && !empty[sel].
- data_o = FIFO[sel][tail[sel]], combinational.
- The VC selection is fixed for the whole packet. Other VCs keep accepting input throughout.

## Timing
- Reset (synchronous, clk_i edge with rst_ni low) drives the following:
  - all FIFOs empty, pointers 0, credit_o all ones;
  - overflow_o, req_o, data_av_o, sending_o all 0;
  - vc_o 0, rr_ptr 0, cnt 0, state IDLE;
  - data_o don't-care.
- Reset asserted mid-packet aborts the packet. Buffered flits are lost.
- Write at edge t: empty clears and credit_o updates after edge t. req_o is high after edge t+1 at the earliest (IDLE->REQ on that edge).
- req_ack_i at edge t: data_av_o is high after edge t if the FIFO is non-empty.
- Back-to-back transfers are possible: one flit per cycle while data_ack_i stays high and the FIFO is non-empty.
- A FIFO underrun mid-packet drops data_av_o low and the FSM holds its state. The packet resumes when data arrives.
- Packet boundary: at least 2 idle cycles (END, IDLE) between the last flit and the next req_o.
- With NUM_VC=1, vc_o stays 0 and the block behaves as a single-VC buffer with credit_o[0] as the credit.

## Test plan
- Single packet, VC0, BUFFER_SIZE=8: flits 0x0011, 0x0003, A, B, C with data_ack_i held high -> req_o two cycles after the first write; 5 transfers in 5 consecutive cycles; sending_o falls after C; rr_ptr=1.
- Size-zero packet: header 0x0022, size 0 -> exactly 2 transfers, then END, then IDLE; no payload is consumed from the FIFO.
- Fill VC1 with 8 flits and no acks -> credit_o[1]=0 after the 8th write, credit_o[0]=1; a 9th write on VC1 is dropped and overflow_o pulses; write-plus-read on full VC1 in one cycle is accepted and credit_o[1] stays 0.
- Fairness, NUM_VC=4, packets pending on VC0, VC2 and VC3 -> service order is 0, 2, 3, then 0; vc_o stays stable for each whole packet; req_o occurs once per packet.
- Wrap with BUFFER_SIZE=5: stream 12 flits through one VC with stalling acks -> output order is identical to input order; pointers wrap from 4 to 0 correctly.
- Reset mid-PAYLOAD -> after the reset edge all outputs are at reset values and credit_o is all ones; a new packet after reset is delivered intact.
